// File: rtl/veggie_banked_pkg.sv
// Shared types and default sizing for the banked vector register file.
package veggie_banked_pkg;

    localparam int VEGGIE_NUM_REGS     = 32;
    localparam int VEGGIE_NUM_ELEMENTS = 16;
    localparam int VEGGIE_ELEM_W       = 16;
    localparam int VEGGIE_NUM_BANKS    = 4;
    localparam int VEGGIE_NUM_RD       = 2;
    localparam int VEGGIE_NUM_WR       = 2;

    localparam int VREG_W = VEGGIE_NUM_ELEMENTS * VEGGIE_ELEM_W;
    localparam int VSEL_W = $clog2(VEGGIE_NUM_REGS);

    typedef logic [VREG_W-1:0]              vreg_t;
    typedef logic [VEGGIE_NUM_ELEMENTS-1:0] vmask_t;
    typedef logic [VSEL_W-1:0]              vsel_t;

    typedef struct packed {
        logic  valid;
        vsel_t addr;
    } veggie_rd_req_t;

    typedef struct packed {
        logic   valid;
        vsel_t  addr;
        vreg_t  data;
        vmask_t mask;
    } veggie_wr_req_t;

    typedef struct packed {
        veggie_rd_req_t [VEGGIE_NUM_RD-1:0] rd;
        veggie_wr_req_t [VEGGIE_NUM_WR-1:0] wr;
    } veggie_in_t;

    typedef struct packed {
        logic  [VEGGIE_NUM_RD-1:0] rd_ready;
        vreg_t [VEGGIE_NUM_RD-1:0] rd_data;
        logic  [VEGGIE_NUM_RD-1:0] rd_data_valid;
        logic  [VEGGIE_NUM_WR-1:0] wr_ready;
    } veggie_out_t;

endpackage

// File: rtl/veggie_banked_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // Search requests starting at the pointer; first hit wins and the pointer moves past it.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                ptr_d      = PW'((int'(idx) + 1) % N);
            end
        end
    end

    // Pointer register; an idle cycle leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/veggie_banked.sv
// Banked vector register file: per-bank RR arbitration for reads and writes,
// masked element writes, 1-cycle read latency with write-first bypass.
module veggie_banked
    import veggie_banked_pkg::*;
#(
    parameter int NUM_REGS     = VEGGIE_NUM_REGS,
    parameter int NUM_ELEMENTS = VEGGIE_NUM_ELEMENTS,
    parameter int ELEM_W       = VEGGIE_ELEM_W,
    parameter int NUM_BANKS    = VEGGIE_NUM_BANKS,
    parameter int NUM_RD       = VEGGIE_NUM_RD,
    parameter int NUM_WR       = VEGGIE_NUM_WR
) (
    input  logic                                                 CLK,
    input  logic                                                 nRST,
    input  logic [NUM_RD-1:0]                                    rd_valid,
    input  logic [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]              rd_addr,
    output logic [NUM_RD-1:0]                                    rd_ready,
    output logic [NUM_RD-1:0][NUM_ELEMENTS*ELEM_W-1:0]           rd_data,
    output logic [NUM_RD-1:0]                                    rd_data_valid,
    input  logic [NUM_WR-1:0]                                    wr_valid,
    input  logic [NUM_WR-1:0][$clog2(NUM_REGS)-1:0]              wr_addr,
    input  logic [NUM_WR-1:0][NUM_ELEMENTS*ELEM_W-1:0]           wr_data,
    input  logic [NUM_WR-1:0][NUM_ELEMENTS-1:0]                  wr_mask,
    output logic [NUM_WR-1:0]                                    wr_ready
);

    localparam int VW = NUM_ELEMENTS * ELEM_W;
    localparam int BW = $clog2(NUM_BANKS);

    logic [VW-1:0]                        mem_q [NUM_REGS];
    logic [NUM_BANKS-1:0][NUM_RD-1:0]     rd_req, rd_gnt;
    logic [NUM_BANKS-1:0][NUM_WR-1:0]     wr_req, wr_gnt;
    logic [NUM_RD-1:0][VW-1:0]            rd_merged;
    logic [NUM_RD-1:0][VW-1:0]            rd_data_q;
    logic [NUM_RD-1:0]                    rd_vld_q;

    // Replace only the elements whose mask bit is set.
    function automatic logic [VW-1:0] apply_mask(input logic [VW-1:0]           old_v,
                                                 input logic [VW-1:0]           new_v,
                                                 input logic [NUM_ELEMENTS-1:0] m);
        logic [VW-1:0] r;
        r = old_v;
        for (int e = 0; e < NUM_ELEMENTS; e++) begin
            if (m[e]) r[e*ELEM_W +: ELEM_W] = new_v[e*ELEM_W +: ELEM_W];
        end
        return r;
    endfunction

    // Route each port's request to the bank selected by the low address bits.
    always_comb begin
        rd_req = '0;
        wr_req = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_RD; p++)
                rd_req[b][p] = rd_valid[p] && (rd_addr[p][BW-1:0] == BW'(b));
            for (int w = 0; w < NUM_WR; w++)
                wr_req[b][w] = wr_valid[w] && (wr_addr[w][BW-1:0] == BW'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_RD)) u_rd_arb (
            .clk_i  (CLK),
            .rst_ni (nRST),
            .req_i  (rd_req[b]),
            .gnt_o  (rd_gnt[b])
        );
        rr_arbiter #(.N(NUM_WR)) u_wr_arb (
            .clk_i  (CLK),
            .rst_ni (nRST),
            .req_i  (wr_req[b]),
            .gnt_o  (wr_gnt[b])
        );
    end

    // A port is ready when its bank's arbiter picked it; a port only requests one bank.
    always_comb begin
        rd_ready = '0;
        wr_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_ready = rd_ready | rd_gnt[b];
            wr_ready = wr_ready | wr_gnt[b];
        end
    end

    // Read value with write-first bypass of any same-cycle granted write to that register.
    always_comb begin
        rd_merged = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_merged[p] = mem_q[rd_addr[p]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ready[w] && (wr_addr[w] == rd_addr[p]))
                    rd_merged[p] = apply_mask(rd_merged[p], wr_data[w], wr_mask[w]);
            end
        end
    end

    // Register storage; at most one write per bank per cycle, so ports never collide.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ready[w])
                    mem_q[wr_addr[w]] <= apply_mask(mem_q[wr_addr[w]], wr_data[w], wr_mask[w]);
            end
        end
    end

    // Read output stage: data captured on grant and held otherwise; valid marks fresh data.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_data_q <= '0;
            rd_vld_q  <= '0;
        end else begin
            rd_vld_q <= rd_ready;
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_ready[p]) rd_data_q[p] <= rd_merged[p];
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_vld_q;

endmodule

// File: tb/tb_veggie_banked.sv
// Directed testbench for veggie_banked with default parameters.
module tb_veggie_banked;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [1:0]        rd_valid;
    logic [1:0][4:0]   rd_addr;
    logic [1:0]        rd_ready;
    logic [1:0][255:0] rd_data;
    logic [1:0]        rd_data_valid;
    logic [1:0]        wr_valid;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][255:0] wr_data;
    logic [1:0][15:0]  wr_mask;
    logic [1:0]        wr_ready;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 CLK = ~CLK;

    veggie_banked dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_ready      (wr_ready)
    );

    task automatic clr();
        rd_valid = '0;
        wr_valid = '0;
    endtask

    // Single uncontended write, one cycle.
    task automatic wr1(input int p, input logic [4:0] a, input logic [255:0] d, input logic [15:0] m);
        @(negedge CLK);
        clr();
        wr_valid[p] = 1'b1;
        wr_addr[p]  = a;
        wr_data[p]  = d;
        wr_mask[p]  = m;
        @(posedge CLK);
        #1;
        clr();
    endtask

    // Single uncontended read; returns the value presented the cycle after the grant.
    task automatic rd1(input int p, input logic [4:0] a, output logic [255:0] d, output logic v);
        @(negedge CLK);
        clr();
        rd_valid[p] = 1'b1;
        rd_addr[p]  = a;
        @(posedge CLK);
        #1;
        clr();
        d = rd_data[p];
        v = rd_data_valid[p];
    endtask

    task automatic test_reset();
        logic [255:0] d;
        logic         v;
        nRST = 1'b0;
        clr();
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        repeat (2) @(negedge CLK);
        total_cnt++;
        if (rd_data_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=%b", rd_data_valid, 2'b00);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== '0) $display("FAIL reset_data got=%h exp=0", rd_data);
        else pass_cnt++;
        nRST = 1'b1;

        wr1(0, 5'd3, {16{16'h7777}}, 16'hFFFF);
        rd1(0, 5'd3, d, v);
        total_cnt++;
        if (d !== {16{16'h7777}}) $display("FAIL pre_reset_v3 got=%h exp=%h", d, {16{16'h7777}});
        else pass_cnt++;

        // write v3 and read it while reset is asserted mid-cycle
        @(negedge CLK);
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = {16{16'h5555}}; wr_mask[0] = 16'hFFFF;
        rd_valid[1] = 1'b1; rd_addr[1] = 5'd3;
        #2 nRST = 1'b0;
        @(posedge CLK);
        #1;
        total_cnt++;
        if (rd_data_valid !== 2'b00) $display("FAIL rst_mid_valid got=%b exp=%b", rd_data_valid, 2'b00);
        else pass_cnt++;
        total_cnt++;
        if (rd_data[0] !== '0) $display("FAIL rst_mid_data got=%h exp=0", rd_data[0]);
        else pass_cnt++;
        clr();
        @(negedge CLK);
        nRST = 1'b1;
        rd1(0, 5'd3, d, v);
        total_cnt++;
        if (d !== '0) $display("FAIL rst_v3_cleared got=%h exp=0", d);
        else pass_cnt++;
        total_cnt++;
        if (v !== 1'b1) $display("FAIL rst_v3_valid got=%b exp=1", v);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [255:0] d;
        logic         v;
        wr1(0, 5'd5, {16{16'h1111}}, 16'hFFFF);
        rd1(0, 5'd5, d, v);
        total_cnt++;
        if (d !== {16{16'h1111}}) $display("FAIL basic_data got=%h exp=%h", d, {16{16'h1111}});
        else pass_cnt++;
        total_cnt++;
        if (v !== 1'b1) $display("FAIL basic_valid got=%b exp=1", v);
        else pass_cnt++;
        // idle cycle: valid drops, data holds
        @(posedge CLK);
        #1;
        total_cnt++;
        if (rd_data_valid[0] !== 1'b0) $display("FAIL idle_valid got=%b exp=0", rd_data_valid[0]);
        else pass_cnt++;
        total_cnt++;
        if (rd_data[0] !== {16{16'h1111}}) $display("FAIL idle_hold got=%h exp=%h", rd_data[0], {16{16'h1111}});
        else pass_cnt++;
    endtask

    task automatic test_masked();
        logic [255:0] d;
        logic         v;
        logic [255:0] e;
        e = {{12{16'h1111}}, {4{16'hAAAA}}};
        wr1(1, 5'd5, {16{16'hAAAA}}, 16'h000F);
        rd1(1, 5'd5, d, v);
        total_cnt++;
        if (d !== e) $display("FAIL masked_data got=%h exp=%h", d, e);
        else pass_cnt++;
        // zero mask changes nothing
        wr1(0, 5'd5, {16{16'hFFFF}}, 16'h0000);
        rd1(0, 5'd5, d, v);
        total_cnt++;
        if (d !== e) $display("FAIL mask0_noop got=%h exp=%h", d, e);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [255:0] d;
        logic         v;
        logic [255:0] e;
        e = {{8{16'h3333}}, {8{16'h2222}}};
        wr1(0, 5'd7, {16{16'h3333}}, 16'hFFFF);
        @(negedge CLK);
        wr_valid[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = {16{16'h2222}}; wr_mask[0] = 16'h00FF;
        rd_valid[0] = 1'b1; rd_addr[0] = 5'd7;
        #1;
        total_cnt++;
        if ({wr_ready[0], rd_ready[0]} !== 2'b11) $display("FAIL bypass_ready got=%b exp=11", {wr_ready[0], rd_ready[0]});
        else pass_cnt++;
        @(posedge CLK);
        #1;
        clr();
        total_cnt++;
        if (rd_data[0] !== e) $display("FAIL bypass_data got=%h exp=%h", rd_data[0], e);
        else pass_cnt++;
        rd1(0, 5'd7, d, v);
        total_cnt++;
        if (d !== e) $display("FAIL bypass_commit got=%h exp=%h", d, e);
        else pass_cnt++;
    endtask

    task automatic test_rd_conflict();
        logic [1:0]   eg;
        logic [255:0] ed;
        int           gp;
        wr1(0, 5'd0, {16{16'h0A0A}}, 16'hFFFF);
        wr1(1, 5'd4, {16{16'h0404}}, 16'hFFFF);
        for (int c = 0; c < 4; c++) begin
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            gp = (c % 2 == 0) ? 0 : 1;
            ed = (c % 2 == 0) ? {16{16'h0A0A}} : {16{16'h0404}};
            @(negedge CLK);
            rd_valid = 2'b11; rd_addr[0] = 5'd0; rd_addr[1] = 5'd4;
            #1;
            total_cnt++;
            if (rd_ready !== eg) $display("FAIL rr_ready[%0d] got=%b exp=%b", c, rd_ready, eg);
            else pass_cnt++;
            @(posedge CLK);
            #1;
            total_cnt++;
            if (rd_data_valid !== eg || rd_data[gp] !== ed)
                $display("FAIL rr_data[%0d] got=%b/%h exp=%b/%h", c, rd_data_valid, rd_data[gp], eg, ed);
            else pass_cnt++;
        end
        clr();
        // different banks: both writes and both reads in the same cycle
        @(negedge CLK);
        wr_valid = 2'b11;
        wr_addr[0] = 5'd1; wr_data[0] = {16{16'h0101}}; wr_mask[0] = 16'hFFFF;
        wr_addr[1] = 5'd2; wr_data[1] = {16{16'h0202}}; wr_mask[1] = 16'hFFFF;
        #1;
        total_cnt++;
        if (wr_ready !== 2'b11) $display("FAIL par_wr_ready got=%b exp=11", wr_ready);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        clr();
        @(negedge CLK);
        rd_valid = 2'b11; rd_addr[0] = 5'd1; rd_addr[1] = 5'd2;
        #1;
        total_cnt++;
        if (rd_ready !== 2'b11) $display("FAIL par_rd_ready got=%b exp=11", rd_ready);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        clr();
        total_cnt++;
        if (rd_data_valid !== 2'b11 || rd_data[0] !== {16{16'h0101}} || rd_data[1] !== {16{16'h0202}})
            $display("FAIL par_rd_data got=%b/%h/%h exp=11/%h/%h", rd_data_valid, rd_data[0], rd_data[1],
                     {16{16'h0101}}, {16{16'h0202}});
        else pass_cnt++;
    endtask

    task automatic test_wr_conflict();
        logic [255:0] d;
        logic         v;
        @(negedge CLK);
        wr_valid = 2'b11;
        wr_addr[0] = 5'd8; wr_data[0] = {16{16'h0001}}; wr_mask[0] = 16'hFFFF;
        wr_addr[1] = 5'd8; wr_data[1] = {16{16'h0002}}; wr_mask[1] = 16'hFFFF;
        #1;
        total_cnt++;
        if (wr_ready !== 2'b01) $display("FAIL wrc_first got=%b exp=01", wr_ready);
        else pass_cnt++;
        @(posedge CLK);
        @(negedge CLK);
        wr_valid[0] = 1'b0;
        #1;
        total_cnt++;
        if (wr_ready !== 2'b10) $display("FAIL wrc_second got=%b exp=10", wr_ready);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        clr();
        rd1(0, 5'd8, d, v);
        total_cnt++;
        if (d !== {16{16'h0002}}) $display("FAIL wrc_final got=%h exp=%h", d, {16{16'h0002}});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_bypass();
        test_rd_conflict();
        test_wr_conflict();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
